// File: rtl/reg_bank_pkg.sv
// Shared encodings for the register-bank multiplexer: command modes and FSM states.
package reg_bank_pkg;

    localparam logic [1:0] MODE_HOLD    = 2'd0;
    localparam logic [1:0] MODE_LOAD_V1 = 2'd1;
    localparam logic [1:0] MODE_LOAD_V2 = 2'd2;
    localparam logic [1:0] MODE_SWAP    = 2'd3;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_SWAP_WB = 1'b1;

endpackage

// File: rtl/reg_bank_core.sv
// Register array: one synchronous write port, two asynchronous read ports, reset-clear.
module reg_bank_core #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b
);

    logic [NREGS-1:0][WIDTH-1:0] regs_q;

    // Decoding per index drops writes and zeroes reads for addresses >= NREGS.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (we && waddr == AW'(i))
                    regs_q[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (raddr_a == AW'(i)) rdata_a = regs_q[i];
            if (raddr_b == AW'(i)) rdata_b = regs_q[i];
        end
    end

endmodule

// File: rtl/reg_bank_mux.sv
// Register bank with a shared write port, registered dual read and a two-cycle SWAP.
module reg_bank_mux
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       state,
    input  logic [AW-1:0]    dest,
    input  logic [AW-1:0]    src_a,
    input  logic [AW-1:0]    src_b,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic [WIDTH-1:0] Output1,
    output logic [WIDTH-1:0] Output2,
    output logic             busy,
    output logic             valid
);

    logic [0:0]       st_q, st_d;
    logic [WIDTH-1:0] tmp_q, tmp_d;
    logic [AW-1:0]    swb_q, swb_d;
    logic [WIDTH-1:0] out1_q, out1_d, out2_q, out2_d;
    logic             vld_q, vld_d;

    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rd_a, rd_b;

    reg_bank_core #(.WIDTH(WIDTH), .NREGS(NREGS)) u_core (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (src_a),
        .raddr_b (src_b),
        .rdata_a (rd_a),
        .rdata_b (rd_b)
    );

    always_comb begin
        st_d   = ST_IDLE;
        tmp_d  = tmp_q;
        swb_d  = swb_q;
        out1_d = out1_q;
        out2_d = out2_q;
        vld_d  = 1'b0;
        we     = 1'b0;
        waddr  = dest;
        wdata  = value1;
        if (st_q == ST_SWAP_WB) begin
            // Second half of SWAP owns the write port; every input is ignored.
            we    = 1'b1;
            waddr = swb_q;
            wdata = tmp_q;
        end else if (en) begin
            out1_d = rd_a;
            out2_d = rd_b;
            vld_d  = 1'b1;
            case (state)
                MODE_LOAD_V1: we = 1'b1;
                MODE_LOAD_V2: begin
                    we    = 1'b1;
                    wdata = value2;
                end
                MODE_SWAP: begin
                    we    = 1'b1;
                    waddr = src_a;
                    wdata = rd_b;
                    tmp_d = rd_a;
                    swb_d = src_b;
                    st_d  = ST_SWAP_WB;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= ST_IDLE;
            tmp_q  <= '0;
            swb_q  <= '0;
            out1_q <= '0;
            out2_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            tmp_q  <= tmp_d;
            swb_q  <= swb_d;
            out1_q <= out1_d;
            out2_q <= out2_d;
            vld_q  <= vld_d;
        end
    end

    assign Output1 = out1_q;
    assign Output2 = out2_q;
    assign busy    = (st_q == ST_SWAP_WB);
    assign valid   = vld_q;

endmodule
